sram_fifo_prefetch: RTL and testbench
=====================================

SRAM_FIFO_PREFETCH -- requirements
Module: sram_fifo_prefetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each data word.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, number of prefetch buffer entries; legal values 2..4.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  synchronous flush of buffer and in-flight reads.
REQ-006 SHALL have port fifo_empty_i  input  1  empty flag of the upstream SRAM FIFO.
REQ-007 SHALL have port fifo_data_i  input  DATA_WIDTH  upstream SRAM FIFO read data, valid one cycle after pop.
REQ-008 SHALL have port fifo_pop_o  output  1  read enable to the upstream SRAM FIFO.
REQ-009 SHALL have port valid_o  output  1  head word valid toward the consumer.
REQ-010 SHALL have port data_o  output  DATA_WIDTH  head word toward the consumer.
REQ-011 SHALL have port ready_i  input  1  consumer accepts the head word.
REQ-012 SHALL have port count_o  output  $clog2(BUF_DEPTH+1)  number of valid buffered words.

Function
REQ-013 SHALL convert the upstream pop/1-cycle-latency read interface into a valid/ready stream.
REQ-014 SHALL define transfer as valid_o && ready_i on a rising edge.
REQ-015 SHALL assert fifo_pop_o only when !fifo_empty_i && !flush_i && (count + inflight - transfer) < BUF_DEPTH.
REQ-016 SHALL set inflight (1 bit) to the fifo_pop_o value each cycle; capture fifo_data_i into the buffer tail in the cycle where inflight=1.
REQ-017 SHALL drive valid_o = (count != 0) and data_o = buffer head; both from registers, no combinational path from fifo_data_i.
REQ-018 SHALL produce valid_o two cycles after the cycle fifo_pop_o is asserted into an empty buffer.
REQ-019 SHALL sustain one transfer per cycle when upstream stays non-empty and ready_i stays high.
REQ-020 SHALL handle simultaneous capture and transfer in one cycle: count unchanged, head advances, new word at tail.
REQ-021 SHALL never overflow: count + inflight SHALL never exceed BUF_DEPTH.
REQ-022 SHALL hold data_o and valid_o stable while valid_o && !ready_i.
REQ-023 SHALL use wrap-around read/write pointers modulo BUF_DEPTH, each advancing by one per capture/transfer.
REQ-024 SHALL on flush_i: next cycle count=0, inflight=0, pointers=0, valid_o=0; the word returned for any pop issued the cycle before flush SHALL be discarded.
REQ-025 SHALL ignore ready_i while valid_o=0.

Reset
REQ-026 SHALL on rst_ni=0 asynchronously clear count, inflight, pointers; valid_o=0, fifo_pop_o=0, count_o=0, data_o=0.
REQ-027 SHALL, on reset asserted mid-operation, discard buffered and in-flight words with no pop issued until after release.
REQ-028 SHALL need no buffer-data reset beyond data_o reading 0 when empty after reset.

Structure
REQ-029 SHALL take the upstream read latency constant (SRAM_FIFO_RD_LATENCY = 1) from shared package sram_fifo_pkg.
REQ-030 SHALL keep the buffer storage as flops in this module; no sub-module required, optional sub-module sram_fifo_ptr for pointer/count logic.

Verification
REQ-031 Reset release, fifo_empty_i=0, word 0xA5A5_0001, ready_i=0 -> pop at cycle 0, valid_o=1 with data_o=0xA5A5_0001 at cycle 2, exactly BUF_DEPTH pops total, no more until ready_i.
REQ-032 Upstream holds 0x1..0x10, ready_i=1 constant -> 16 transfers on 16 consecutive cycles after initial 2-cycle latency, in order.
REQ-033 Random ready_i (50%) over 1000 words -> output sequence equals input sequence, count_o <= BUF_DEPTH always.
REQ-034 flush_i in the cycle after a pop with 2 words buffered -> next cycle valid_o=0, count_o=0; the in-flight word never appears on data_o.
REQ-035 fifo_empty_i toggling every cycle with ready_i=1 -> no pop while empty, no lost or duplicated word.
REQ-036 rst_ni pulsed low mid-stream with count_o=2 -> outputs zero immediately (asynchronously), stream resumes cleanly after release.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// Shared definitions for the SRAM FIFO prefetch path: upstream read latency and
// the modulo pointer increment used by the prefetch buffer.
package sram_fifo_pkg;

    localparam int SRAM_FIFO_RD_LATENCY = 1;

    function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
        if (ptr >= depth - 32'd1) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/sram_fifo_ptr.sv
// Pointer, occupancy and in-flight tracking for the prefetch buffer. Also
// exposes the next-state read pointer and count so the top can preload its head.
module sram_fifo_ptr
    import sram_fifo_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int PTR_W     = $clog2(BUF_DEPTH),
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             pop_i,
    input  logic             transfer_i,
    output logic             inflight_o,
    output logic             capture_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_nxt_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_nxt_o
);

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_s;
    logic [PTR_W-1:0] wr_ptr_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             inflight_r;

    // A word returning during a flush belongs to the discarded stream.
    assign capture_o    = inflight_r & ~flush_i;
    assign inflight_o   = inflight_r;
    assign wr_ptr_o     = wr_ptr_r;
    assign rd_ptr_nxt_o = rd_ptr_s;
    assign count_o      = count_r;
    assign count_nxt_o  = count_s;

    // Next pointers and count from capture / transfer / flush.
    always_comb begin
        rd_ptr_s = rd_ptr_r;
        wr_ptr_s = wr_ptr_r;
        count_s  = count_r;
        if (flush_i) begin
            rd_ptr_s = {PTR_W{1'b0}};
            wr_ptr_s = {PTR_W{1'b0}};
            count_s  = {CNT_W{1'b0}};
        end else begin
            if (capture_o) begin
                wr_ptr_s = PTR_W'(ptr_wrap_inc(32'(wr_ptr_r), BUF_DEPTH));
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (transfer_i) begin
                rd_ptr_s = PTR_W'(ptr_wrap_inc(32'(rd_ptr_r), BUF_DEPTH));
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({capture_o, transfer_i})
                2'b10:   count_s = count_r + CNT_W'(1);
                2'b01:   count_s = count_r - CNT_W'(1);
                default: count_s = count_r;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            rd_ptr_r   <= rd_ptr_s;
            wr_ptr_r   <= wr_ptr_s;
            count_r    <= count_s;
            inflight_r <= pop_i;
        end
    end

endmodule

// File: rtl/sram_fifo_prefetch.sv
// Prefetch buffer turning an upstream pop / fixed-latency SRAM FIFO read port
// into a registered valid/ready stream.
module sram_fifo_prefetch
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]          fifo_data_i,
    output logic                           fifo_pop_o,
    output logic                           valid_o,
    output logic [DATA_WIDTH-1:0]          data_o,
    input  logic                           ready_i,
    output logic [$clog2(BUF_DEPTH+1)-1:0] count_o
);

    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int OCC_W     = CNT_W + 1;
    // Room must remain for every word still travelling through the SRAM read latency.
    localparam int POP_LIMIT = BUF_DEPTH - SRAM_FIFO_RD_LATENCY;

    logic [DATA_WIDTH-1:0] buf_r [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] head_s;
    logic                  valid_r;
    logic                  transfer_s;
    logic                  pop_s;
    logic                  inflight_s;
    logic                  capture_s;
    logic [PTR_W-1:0]      wr_ptr_s;
    logic [PTR_W-1:0]      rd_ptr_nxt_s;
    logic [CNT_W-1:0]      count_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [OCC_W-1:0]      occ_s;

    assign transfer_s = valid_r & ready_i;
    assign occ_s      = OCC_W'(count_s) + OCC_W'(inflight_s) - OCC_W'(transfer_s);
    assign pop_s      = rst_ni & ~fifo_empty_i & ~flush_i & (occ_s <= OCC_W'(POP_LIMIT));

    assign fifo_pop_o = pop_s;
    assign valid_o    = valid_r;
    assign data_o     = data_r;
    assign count_o    = count_s;

    sram_fifo_ptr #(
        .BUF_DEPTH (BUF_DEPTH),
        .PTR_W     (PTR_W),
        .CNT_W     (CNT_W)
    ) u_ptr (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .pop_i        (pop_s),
        .transfer_i   (transfer_s),
        .inflight_o   (inflight_s),
        .capture_o    (capture_s),
        .wr_ptr_o     (wr_ptr_s),
        .rd_ptr_nxt_o (rd_ptr_nxt_s),
        .count_o      (count_s),
        .count_nxt_o  (count_nxt_s)
    );

    // Buffer storage; contents only matter where count marks them valid.
    always_ff @(posedge clk_i) begin
        if (capture_s) begin
            buf_r[wr_ptr_s] <= fifo_data_i;
        end
    end

    // Next head word: a capture into an otherwise drained buffer bypasses storage.
    always_comb begin
        head_s = buf_r[rd_ptr_nxt_s];
        if (capture_s && (wr_ptr_s == rd_ptr_nxt_s)) begin
            head_s = fifo_data_i;
        end else begin
            head_s = buf_r[rd_ptr_nxt_s];
        end
    end

    // Registered consumer-side outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
        end else if (flush_i) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            if (count_nxt_s != {CNT_W{1'b0}}) begin
                data_r <= head_s;
            end else begin
                data_r <= data_r;
            end
        end
    end

endmodule

// File: tb/tb_sram_fifo_prefetch.sv
// Self-checking bench: upstream SRAM FIFO model, scoreboard of popped words,
// cycle table for the start-up sequence and directed multi-cycle scenarios.
module tb_sram_fifo_prefetch;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          fifo_empty_i;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_pop_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          ready_i;
    logic [CW-1:0] count_o;

    always #5 clk_i = ~clk_i;

    sram_fifo_prefetch #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .ready_i      (ready_i),
        .count_o      (count_o)
    );

    typedef struct {
        logic       ready;
        logic       flush;
        logic       pop;
        logic       valid;
        logic [1:0] count;
    } vec_t;

    int            total = 0;
    int            bad   = 0;
    int            n_out = 0;
    int            m_count = 0;
    int            m_inf   = 0;
    int            m_tr    = 0;
    int            m_pop   = 0;
    logic          hold_empty;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive upstream empty flag, then compare DUT against the model mid-cycle.
    task automatic drive_and_check();
        fifo_empty_i = hold_empty || (src_q.size() == 0);
        #2;
        m_tr  = (m_count != 0 && ready_i) ? 1 : 0;
        m_pop = (!fifo_empty_i && !flush_i && (m_count + m_inf - m_tr < DEPTH)) ? 1 : 0;
        chk("pop", 64'(fifo_pop_o), 64'(m_pop));
        chk("valid", 64'(valid_o), 64'(m_count != 0));
        chk("count", 64'(count_o), 64'(m_count));
        if (m_tr == 1 && !flush_i) begin
            n_out++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL data: got %0h expected no word at %0t", data_o, $time);
            end else begin
                chk("data", 64'(data_o), 64'(exp_q.pop_front()));
            end
        end
    endtask

    // Advance one edge: update the model and return the popped word a cycle later.
    task automatic advance();
        logic [DW-1:0] w;
        w = 32'hDEAD_BEEF;
        @(posedge clk_i);
        if (flush_i) begin
            m_count = 0;
            m_inf   = 0;
            exp_q.delete();
        end else begin
            m_count = m_count + m_inf - m_tr;
            m_inf   = m_pop;
        end
        if (m_pop == 1) begin
            w = src_q.pop_front();
            exp_q.push_back(w);
        end
        #1;
        fifo_data_i = w;
    endtask

    task automatic tick();
        drive_and_check();
        advance();
    endtask

    vec_t vecs[13];
    int   first_k;
    int   last_k;
    int   prev;
    int   base;
    int   cyc;
    int   remain;

    initial begin
        // Start-up after reset: ready low until cycle 4, flush with a word in flight.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1};

        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        ready_i      = 1'b0;
        hold_empty   = 1'b0;
        fifo_data_i  = 32'hDEAD_BEEF;
        for (int i = 0; i < 64; i++) src_q.push_back(32'hA5A5_0001 + 32'(i));
        fifo_empty_i = 1'b0;
        #12;
        chk("rst_pop", 64'(fifo_pop_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 13; i++) begin
            ready_i = vecs[i].ready;
            flush_i = vecs[i].flush;
            drive_and_check();
            chk($sformatf("vec%0d_pop", i), 64'(fifo_pop_o), 64'(vecs[i].pop));
            chk($sformatf("vec%0d_valid", i), 64'(valid_o), 64'(vecs[i].valid));
            chk($sformatf("vec%0d_count", i), 64'(count_o), 64'(vecs[i].count));
            advance();
        end
        flush_i = 1'b0;

        // Drain, then a fresh 16-word stream with ready held high.
        hold_empty = 1'b1;
        ready_i    = 1'b1;
        for (int i = 0; i < 20 && (m_count != 0 || m_inf != 0); i++) tick();
        src_q.delete();
        for (int i = 1; i <= 16; i++) src_q.push_back(32'(i));
        hold_empty = 1'b0;
        first_k = -1;
        last_k  = -1;
        base    = n_out;
        for (int k = 0; k < 40; k++) begin
            prev = n_out;
            tick();
            if (n_out > prev) begin
                if (first_k < 0) first_k = k;
                last_k = k;
            end
        end
        chk("stream_words", 64'(n_out - base), 64'd16);
        chk("stream_first", 64'(first_k), 64'd2);
        chk("stream_span", 64'(last_k - first_k), 64'd15);

        // 1000 random words with random backpressure.
        for (int i = 0; i < 1000; i++) src_q.push_back($urandom);
        base = n_out;
        cyc  = 0;
        while ((n_out - base) < 1000 && cyc < 6000) begin
            ready_i = 1'($urandom_range(0, 1));
            tick();
            if (count_o > CW'(DEPTH)) chk("count_bound", 64'(count_o), 64'(DEPTH));
            cyc++;
        end
        chk("random_words", 64'(n_out - base), 64'd1000);
        chk("random_drain", 64'(exp_q.size()), 64'd0);

        // Upstream empty toggling every cycle.
        for (int i = 0; i < 16; i++) src_q.push_back(32'h0BAD_0000 + 32'(i));
        ready_i = 1'b1;
        base    = n_out;
        for (int k = 0; k < 100 && (n_out - base) < 16; k++) begin
            hold_empty = 1'(k % 2);
            tick();
        end
        hold_empty = 1'b0;
        chk("toggle_words", 64'(n_out - base), 64'd16);

        // Asynchronous reset with two words buffered.
        for (int i = 0; i < 20; i++) src_q.push_back(32'hC0DE_0000 + 32'(i));
        ready_i = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_count", 64'(count_o), 64'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(valid_o), 64'd0);
        chk("arst_count", 64'(count_o), 64'd0);
        chk("arst_data", 64'(data_o), 64'd0);
        chk("arst_pop", 64'(fifo_pop_o), 64'd0);
        m_count = 0;
        m_inf   = 0;
        exp_q.delete();
        @(posedge clk_i);
        #1;
        chk("arst_pop_hold", 64'(fifo_pop_o), 64'd0);
        fifo_data_i = 32'hDEAD_BEEF;
        rst_ni = 1'b1;
        remain  = src_q.size();
        ready_i = 1'b1;
        base    = n_out;
        for (int k = 0; k < 100 && (n_out - base) < remain; k++) tick();
        chk("resume_words", 64'(n_out - base), 64'(remain));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
